prog_sequencer: RTL and testbench

//  Run controller in front of the PC. Takes a start/done handshake from the host

---
 rtl/prog_seq_pkg.sv | 19 +
 rtl/run_watchdog.sv | 32 +++
 rtl/prog_sequencer.sv | 157 +++++++++++++++
 tb/tb_prog_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared widths and FSM state encoding for the program run sequencer.
//   PC_W   : program counter / address width
//   CNT_W  : run cycle counter width
//   ST_*   : sequencer states (3-bit constants)
package prog_seq_pkg;

    localparam int unsigned PC_W  = 12;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ST_W  = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_ENTER = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/run_watchdog.sv
// Saturating run-cycle counter with watchdog compare.
//   CLK    : clock, rising edge
//   clear  : synchronous clear of the counter (takes priority)
//   enable : count this cycle
//   count  : cycles counted since last clear, saturates at all-ones
//   expire : count has reached WATCHDOG-1, so the current cycle is the last allowed
module run_watchdog
    import prog_seq_pkg::*;
#(
    parameter int unsigned WATCHDOG = 4095
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WATCHDOG - 1);

    // Counter holds at all-ones rather than wrapping.
    always_ff @(posedge CLK) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/prog_sequencer.sv
// Run controller in front of the PC: start/done host handshake, entry-point
// selection, PC init/branch steering, halt/watchdog run termination.
//   CLK, init                  : clock and synchronous active-high reset
//   start, prog_sel            : host run request and program select
//   core_branch_en, core_target: branch request passed through during RUN
//   pc_halt, pc_value          : PC status
//   pc_init, pc_branch_en,
//   pc_target                  : combinational PC controls
//   busy, done, timeout,
//   cycle_count, final_pc      : registered run status
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] ENTRY0   = 12'd0,
    parameter logic [PC_W-1:0] ENTRY1   = 12'd151,
    parameter logic [PC_W-1:0] ENTRY2   = 12'd623,
    parameter logic [PC_W-1:0] ENTRY3   = 12'd0,
    parameter int unsigned     WATCHDOG = 4095
) (
    input  logic             CLK,
    input  logic             init,
    input  logic             start,
    input  logic [1:0]       prog_sel,
    input  logic             core_branch_en,
    input  logic [PC_W-1:0]  core_target,
    input  logic             pc_halt,
    input  logic [PC_W-1:0]  pc_value,
    output logic             pc_init,
    output logic             pc_branch_en,
    output logic [PC_W-1:0]  pc_target,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  final_pc
);

    state_t          state;
    state_t          next_state;
    logic [1:0]      sel_q;
    logic [PC_W-1:0] entry_addr_c;
    logic            launch_c;
    logic            run_end_c;
    logic            wd_expire_c;
    logic            wd_clear_c;
    logic            wd_enable_c;

    // Entry point for the program latched at launch.
    always_comb begin
        entry_addr_c = ENTRY0;
        case (sel_q)
            2'd1:    entry_addr_c = ENTRY1;
            2'd2:    entry_addr_c = ENTRY2;
            2'd3:    entry_addr_c = ENTRY3;
            default: entry_addr_c = ENTRY0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (init) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and combinational PC controls.
    always_comb begin
        next_state   = state;
        pc_init      = init;
        pc_branch_en = 1'b0;
        pc_target    = '0;
        launch_c     = 1'b0;
        run_end_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    launch_c   = 1'b1;
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // A stale halt only gets cleared this edge; the PC zeroes on the next.
                pc_init = 1'b1;
                if (!pc_halt) begin
                    next_state = ST_ENTER;
                end
            end
            ST_ENTER: begin
                pc_branch_en = 1'b1;
                pc_target    = entry_addr_c;
                next_state   = ST_RUN;
            end
            ST_RUN: begin
                pc_branch_en = core_branch_en & ~pc_halt;
                pc_target    = core_target;
                if (pc_halt || wd_expire_c) begin
                    run_end_c  = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (init) begin
            next_state   = ST_IDLE;
            pc_branch_en = 1'b0;
            pc_target    = '0;
            launch_c     = 1'b0;
            run_end_c    = 1'b0;
        end
    end

    // Registered run status; busy/done track the state being entered.
    always_ff @(posedge CLK) begin
        if (init) begin
            sel_q    <= 2'd0;
            timeout  <= 1'b0;
            final_pc <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (next_state == ST_CLEAR) || (next_state == ST_ENTER) ||
                    (next_state == ST_RUN);
            done <= (next_state == ST_DONE);
            if (launch_c) begin
                sel_q    <= prog_sel;
                timeout  <= 1'b0;
                final_pc <= '0;
            end
            // Halt wins over a simultaneous watchdog expiry.
            if (run_end_c) begin
                final_pc <= pc_value;
                timeout  <= ~pc_halt;
            end
        end
    end

    assign wd_clear_c  = init | launch_c;
    assign wd_enable_c = (state == ST_RUN);

    run_watchdog #(
        .WATCHDOG (WATCHDOG)
    ) u_watchdog (
        .CLK    (CLK),
        .clear  (wd_clear_c),
        .enable (wd_enable_c),
        .count  (cycle_count),
        .expire (wd_expire_c)
    );

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: reset checks, a cycle table, directed
// multi-cycle sequences and randomized runs against a run-level reference model.
module tb_prog_sequencer;

    localparam int unsigned WD = 20;

    logic        CLK = 1'b0;
    logic        init;
    logic        start;
    logic [1:0]  prog_sel;
    logic        core_branch_en;
    logic [11:0] core_target;
    logic        pc_halt;
    logic [11:0] pc_value;
    logic        pc_init;
    logic        pc_branch_en;
    logic [11:0] pc_target;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [11:0] final_pc;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    prog_sequencer #(
        .WATCHDOG (WD)
    ) dut (
        .CLK            (CLK),
        .init           (init),
        .start          (start),
        .prog_sel       (prog_sel),
        .core_branch_en (core_branch_en),
        .core_target    (core_target),
        .pc_halt        (pc_halt),
        .pc_value       (pc_value),
        .pc_init        (pc_init),
        .pc_branch_en   (pc_branch_en),
        .pc_target      (pc_target),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .final_pc       (final_pc)
    );

    typedef struct {
        logic        i_init;
        logic        i_start;
        logic [1:0]  i_sel;
        logic        i_cbr;
        logic [11:0] i_ctgt;
        logic        i_halt;
        logic [11:0] i_pcv;
        logic        e_init;
        logic        e_br;
        logic [11:0] e_tgt;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [11:0] entry_of(input logic [1:0] s);
        case (s)
            2'd1:    return 12'd151;
            2'd2:    return 12'd623;
            default: return 12'd0;
        endcase
    endfunction

    function automatic vec_t mk(input logic i, input logic s, input logic [1:0] sl,
                                input logic cb, input logic [11:0] ct, input logic h,
                                input logic [11:0] pv, input logic ei, input logic eb,
                                input logic [11:0] et, input logic eby, input logic ed);
        vec_t v;
        v.i_init = i;  v.i_start = s;  v.i_sel = sl;  v.i_cbr = cb;  v.i_ctgt = ct;
        v.i_halt = h;  v.i_pcv = pv;   v.e_init = ei; v.e_br = eb;   v.e_tgt = et;
        v.e_busy = eby; v.e_done = ed;
        return v;
    endfunction

    // One complete run from IDLE. The model: the run lasts min(halt_at, WD) RUN
    // cycles (halt_at outside 1..WD means no halt), timeout iff no halt in time,
    // final_pc is pc_value on the last RUN cycle. A stale halt comes from pc_halt.
    task automatic run_prog(input logic [1:0] sel, input int halt_at, input int hold);
        bit          halted;
        int          exp_cyc;
        logic [11:0] exp_fpc;
        halted  = (halt_at >= 1) && (halt_at <= int'(WD));
        exp_cyc = halted ? halt_at : int'(WD);
        exp_fpc = 12'd0;

        start = 1'b1; prog_sel = sel; core_branch_en = 1'b0;
        #1;
        chk("idle_pc_init", pc_init, 0);
        chk("idle_busy", busy, 0);
        tick();

        prog_sel = 2'($urandom);
        if (pc_halt) begin
            #1;
            chk("stale_clear_pc_init", pc_init, 1);
            chk("stale_clear_busy", busy, 1);
            chk("stale_clear_br", pc_branch_en, 0);
            tick();
            pc_halt = 1'b0;
        end
        #1;
        chk("clear_pc_init", pc_init, 1);
        chk("clear_br", pc_branch_en, 0);
        tick();

        core_branch_en = 1'($urandom);
        core_target    = 12'($urandom);
        #1;
        chk("enter_pc_init", pc_init, 0);
        chk("enter_br", pc_branch_en, 1);
        chk("enter_target", pc_target, entry_of(sel));
        tick();

        for (int k = 1; k <= exp_cyc; k++) begin
            pc_halt        = (k == halt_at);
            core_branch_en = 1'($urandom);
            core_target    = 12'($urandom);
            pc_value       = 12'($urandom);
            if (k == exp_cyc) exp_fpc = pc_value;
            #1;
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_br", pc_branch_en, core_branch_en & ~pc_halt);
            if (core_branch_en && !pc_halt) chk("run_target", pc_target, core_target);
            tick();
        end

        // PC halt is sticky until the next CLEAR.
        pc_halt = halted;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_cycle_count", cycle_count, exp_cyc);
        chk("end_timeout", timeout, !halted);
        chk("end_final_pc", final_pc, exp_fpc);

        for (int h = 0; h < hold; h++) begin
            prog_sel = 2'($urandom);
            #1;
            chk("hold_done", done, 1);
            chk("hold_pc_init", pc_init, 0);
            chk("hold_busy", busy, 0);
            tick();
        end
        start = 1'b0;
        #1;
        chk("drop_done", done, 1);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy2", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        init = 1'b1; start = 1'b1; prog_sel = 2'd0; core_branch_en = 1'b1;
        core_target = 12'hFFF; pc_halt = 1'b0; pc_value = 12'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc_init", pc_init, 1);
        chk("rst_br", pc_branch_en, 0);
        chk("rst_target", pc_target, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_final_pc", final_pc, 0);
        init = 1'b0; start = 1'b0; core_branch_en = 1'b0; core_target = 12'd0;

        // IDLE, CLEAR, ENTER, RUN x3 (halt on 3rd), DONE x2, IDLE.
        tbl[0] = mk(1'b0,1'b1,2'd1,1'b0,12'h000,1'b0,12'h000, 1'b0,1'b0,12'd0,  1'b0,1'b0);
        tbl[1] = mk(1'b0,1'b0,2'd3,1'b1,12'h000,1'b0,12'h000, 1'b1,1'b0,12'd0,  1'b1,1'b0);
        tbl[2] = mk(1'b0,1'b0,2'd0,1'b0,12'h055,1'b0,12'h000, 1'b0,1'b1,12'd151,1'b1,1'b0);
        tbl[3] = mk(1'b0,1'b0,2'd0,1'b1,12'h0AB,1'b0,12'h010, 1'b0,1'b1,12'h0AB,1'b1,1'b0);
        tbl[4] = mk(1'b0,1'b0,2'd0,1'b0,12'h0CD,1'b0,12'h011, 1'b0,1'b0,12'h0CD,1'b1,1'b0);
        tbl[5] = mk(1'b0,1'b0,2'd0,1'b1,12'h000,1'b1,12'h456, 1'b0,1'b0,12'd0,  1'b1,1'b0);
        tbl[6] = mk(1'b0,1'b1,2'd2,1'b1,12'h000,1'b1,12'h456, 1'b0,1'b0,12'd0,  1'b0,1'b1);
        tbl[7] = mk(1'b0,1'b0,2'd2,1'b0,12'h000,1'b1,12'h456, 1'b0,1'b0,12'd0,  1'b0,1'b1);
        tbl[8] = mk(1'b0,1'b0,2'd2,1'b0,12'h000,1'b1,12'h456, 1'b0,1'b0,12'd0,  1'b0,1'b0);
        for (int r = 0; r < 9; r++) begin
            init = tbl[r].i_init; start = tbl[r].i_start; prog_sel = tbl[r].i_sel;
            core_branch_en = tbl[r].i_cbr; core_target = tbl[r].i_ctgt;
            pc_halt = tbl[r].i_halt; pc_value = tbl[r].i_pcv;
            #1;
            chk($sformatf("tbl%0d_pc_init", r), pc_init, tbl[r].e_init);
            chk($sformatf("tbl%0d_br", r), pc_branch_en, tbl[r].e_br);
            chk($sformatf("tbl%0d_target", r), pc_target, tbl[r].e_tgt);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
            chk($sformatf("tbl%0d_done", r), done, tbl[r].e_done);
            tick();
        end
        chk("tbl_cycle_count", cycle_count, 3);
        chk("tbl_final_pc", final_pc, 12'h456);
        chk("tbl_timeout", timeout, 0);

        // pc_halt is still high from the table run: stale-halt CLEAR plus halt at 10.
        run_prog(2'd1, 10, 0);
        // Watchdog abort, then halt coinciding with the watchdog limit.
        run_prog(2'd2, 0, 1);
        run_prog(2'd3, int'(WD), 0);
        run_prog(2'd1, 0, 0);

        // init pulsed mid-RUN after a timed-out run left status set.
        start = 1'b1; prog_sel = 2'd1;
        tick(); tick(); tick();
        repeat (5) tick();
        chk("mid_busy", busy, 1);
        init = 1'b1; core_branch_en = 1'b1; core_target = 12'h3C3;
        #1;
        chk("mid_init_pc_init", pc_init, 1);
        chk("mid_init_br", pc_branch_en, 0);
        chk("mid_init_target", pc_target, 0);
        tick();
        init = 1'b0; start = 1'b0; core_branch_en = 1'b0;
        #1;
        chk("mid_busy_after", busy, 0);
        chk("mid_done_after", done, 0);
        chk("mid_cycle_count", cycle_count, 0);
        chk("mid_timeout", timeout, 0);
        chk("mid_final_pc", final_pc, 0);
        chk("mid_idle_pc_init", pc_init, 0);
        tick();

        // start held through DONE, then re-run with prog_sel=2.
        run_prog(2'd0, 4, 5);
        run_prog(2'd2, 2, 0);

        for (int n = 0; n < 15; n++) begin
            run_prog(2'($urandom), int'($urandom_range(0, 24)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
